// File: rtl/online_otf_converter.sv
// Online (MSD-first) signed-digit to two's-complement converter using on-the-fly Q/QM registers.
// Optional ONLINE_OTF_BACKTOBACK_EN: accept the next word's MSD in the same cycle the result is taken.
module online_otf_converter #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_p,
    input  logic       in_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:0] out_data
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [N:0]    q, qm, q_upd, qm_upd;
    logic [CW-1:0] cnt;
    logic          accept, last, dig_pos, dig_neg;

    // Code 11 decodes as zero, same as 00.
    assign dig_pos = in_p & ~in_n;
    assign dig_neg = in_n & ~in_p;
    assign accept  = in_valid & in_ready;
    assign last    = (cnt == CW'(N - 1));

    // QM tracks Q-1, so a -1 digit selects QM instead of propagating a borrow.
    always_comb begin
        q_upd  = {q[N-1:0], 1'b0};
        qm_upd = {qm[N-1:0], 1'b1};
        if (dig_pos) begin
            q_upd  = {q[N-1:0], 1'b1};
            qm_upd = {q[N-1:0], 1'b0};
        end else if (dig_neg) begin
            q_upd  = {qm[N-1:0], 1'b1};
            qm_upd = {qm[N-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && last) state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
`ifdef ONLINE_OTF_BACKTOBACK_EN
                    state_nxt = (accept && last) ? HOLD : COLLECT;
`else
                    state_nxt = COLLECT;
`endif
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
`ifdef ONLINE_OTF_BACKTOBACK_EN
        if (state == HOLD) in_ready = out_ready;
`endif
    end

    // Q/QM are cleared when a word completes, so an MSD accepted in HOLD starts a fresh word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            qm       <= '1;
            cnt      <= '0;
            out_data <= '0;
        end else if (accept) begin
            if (last) begin
                q        <= '0;
                qm       <= '1;
                cnt      <= '0;
                out_data <= q_upd;
            end else begin
                q   <= q_upd;
                qm  <= qm_upd;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
